// File: rtl/tick_event_logger_if.sv
// Read-side valid/ready channel of the tick event logger.
// The logger drives the master side; the reader uses the slave side.
`timescale 1ns/1ps
interface tick_event_logger_if #(
    parameter int DW = 16
);
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/tick_event_logger.sv
// Timestamps every detector tick with a free-running cycle counter and queues
// the stamps in a small FWFT FIFO drained over a valid/ready channel.
`timescale 1ns/1ps
module tick_event_logger #(
    parameter  int TS_W  = 16,
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 clear,
    tick_event_logger_if.master  rd_if,
    output logic [AW:0]          fifo_level,
    output logic [CNT_W-1:0]     tick_count,
    output logic                 overflow
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [TS_W-1:0]  r_rd_data;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [AW:0]      w_level_next;
    logic [TS_W-1:0]  w_head_next;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LEVEL_FULL);
    assign w_pop        = !w_empty && rd_if.rd_ready && !clear;
    // A full FIFO still accepts a tick when the head is popped at the same edge.
    assign w_push       = tick && !clear && (!w_full || w_pop);
    assign w_drop       = tick && !clear && w_full && !w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Next value of the registered head: the incoming stamp when it becomes the
    // only entry, the following slot after a pop, otherwise the last value.
    always_comb begin
        w_head_next = r_rd_data;
        if (w_push && (w_empty || (w_pop && r_level == (AW+1)'(1)))) begin
            w_head_next = r_ts;
        end else if (w_pop && r_level != (AW+1)'(1)) begin
            w_head_next = r_mem[w_rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_rd_data  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts      <= r_ts + 1'b1;
            r_rd_data <= w_head_next;
            r_level   <= w_level_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (tick && !(&r_count)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rd_if.rd_valid = !w_empty;
    assign rd_if.rd_data  = r_rd_data;
    assign fifo_level     = r_level;
    assign tick_count     = r_count;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_tick_event_logger.sv
// Randomized and directed bench for tick_event_logger: a queue-based reference
// model predicts stamps, a negedge monitor checks every read handshake.
`timescale 1ns/1ps
module tb_tick_event_logger;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic             clear = 1'b0;
    logic             tick2 = 1'b0;
    logic [LW-1:0]    fifo_level;
    logic [CNT_W-1:0] tick_count;
    logic             overflow;
    logic [LW-1:0]    lvl2;
    logic [CNT_W-1:0] cnt2;
    logic             ovf2;

    tick_event_logger_if #(.DW(TS_W)) rd_if ();
    tick_event_logger_if #(.DW(4))    rd_if2 ();

    tick_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .clear      (clear),
        .rd_if      (rd_if.master),
        .fifo_level (fifo_level),
        .tick_count (tick_count),
        .overflow   (overflow)
    );

    // Narrow-timestamp instance for the wrap case.
    tick_event_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_w4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick2),
        .clear      (1'b0),
        .rd_if      (rd_if2.master),
        .fifo_level (lvl2),
        .tick_count (cnt2),
        .overflow   (ovf2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycle count since reset/clear, occupancy, counters,
    // and the stamps still expected to come out, oldest first.
    int m_ts;
    int m_level;
    int m_cnt;
    bit m_ovf;
    int sbq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens at the coming edge when valid&&ready hold now.
    always @(negedge clk) begin
        int e;
        if (rst_n && !clear && rd_if.rd_valid && rd_if.rd_ready) begin
            if (sbq.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                $display("pop data=%0d expected=%0d t=%0t", rd_if.rd_data, e, $time);
                chk("pop_data", rd_if.rd_data, e);
            end
        end
    end

    task automatic check_state();
        chk("level", fifo_level, m_level);
        chk("valid", rd_if.rd_valid, (m_level != 0));
        chk("count", tick_count, m_cnt);
        chk("ovf", overflow, m_ovf);
    endtask

    task automatic model_step(input bit t, input bit r, input bit c);
        bit pop;
        if (c) begin
            m_ts = 0; m_level = 0; m_cnt = 0; m_ovf = 0;
            sbq.delete();
            return;
        end
        pop = (m_level > 0) && r;
        if (t) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_level < DEPTH || pop) begin
                sbq.push_back(m_ts);
                m_level++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_level--;
        m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit t, input bit r, input bit c);
        tick = t;
        rd_if.rd_ready = r;
        clear = c;
        @(negedge clk);
        check_state();
        model_step(t, r, c);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset();
        tick = 0; rd_if.rd_ready = 0; clear = 0; tick2 = 0;
        #1;
        rst_n = 0;
        #1;
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_data", rd_if.rd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_count", tick_count, 0);
        chk("rst_ovf", overflow, 0);
        m_ts = 0; m_level = 0; m_cnt = 0; m_ovf = 0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_pct;
        rd_if.rd_ready  = 0;
        rd_if2.rd_ready = 0;
        @(posedge clk);
        #1;

        // 1: idle after reset, then a tick stamped with the elapsed cycles
        do_reset();
        repeat (10) cycle(0, 0, 0);
        chk("t1_count", tick_count, 0);
        chk("t1_valid", rd_if.rd_valid, 0);
        cycle(1, 0, 0);
        chk("t1_stamp", rd_if.rd_data, 10);
        cycle(0, 1, 0);

        // 2: ticks at ts=5 and ts=9, then read both
        do_reset();
        for (int i = 0; i <= 10; i++) cycle(i == 5 || i == 9, 0, 0);
        chk("t2_data", rd_if.rd_data, 5);
        chk("t2_level", fifo_level, 2);
        cycle(0, 1, 0);
        chk("t2_data2", rd_if.rd_data, 9);
        cycle(0, 1, 0);
        chk("t2_empty", rd_if.rd_valid, 0);
        cycle(0, 0, 0);

        // 3: nine ticks into eight slots
        do_reset();
        repeat (9) cycle(1, 0, 0);
        chk("t3_level", fifo_level, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_count", tick_count, 9);
        repeat (10) cycle(0, 1, 0);
        chk("t3_drained", sbq.size(), 0);

        // 4: full FIFO, tick together with a pop
        cycle(0, 0, 1);
        chk("t4_clr_ovf", overflow, 0);
        repeat (8) cycle(1, 0, 0);
        chk("t4_full", fifo_level, 8);
        cycle(1, 1, 0);
        chk("t4_level", fifo_level, 8);
        chk("t4_ovf", overflow, 0);
        repeat (10) cycle(0, 1, 0);

        // 5: counter saturation while draining continuously
        cycle(0, 0, 1);
        repeat (300) cycle(1, 1, 0);
        chk("t5_count", tick_count, 255);
        chk("t5_ovf", overflow, 0);
        repeat (3) cycle(0, 1, 0);

        // 6: clear with a tick and entries queued, then reset mid-burst
        cycle(0, 0, 1);
        repeat (3) cycle(1, 0, 0);
        cycle(1, 0, 1);
        chk("t6_level", fifo_level, 0);
        chk("t6_count", tick_count, 0);
        chk("t6_ovf", overflow, 0);
        cycle(1, 0, 0);
        chk("t6_ts0", rd_if.rd_data, 0);
        repeat (4) cycle(1, 1, 0);
        do_reset();

        // 7: 4-bit timestamp wraps, tick at cycle 17 stamps 1
        for (int i = 0; i < 20; i++) begin
            tick2 = (i == 17);
            cycle(0, 0, 0);
        end
        tick2 = 0;
        chk("t7_valid", rd_if2.rd_valid, 1);
        chk("t7_stamp", rd_if2.rd_data, 17 % 16);
        chk("t7_level", lvl2, 1);
        chk("t7_count", cnt2, 1);
        chk("t7_ovf", ovf2, 0);

        // Random traffic with varying reader pressure and occasional clears
        do_reset();
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(5, 95);
            cycle($urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 149) == 0);
        end
        repeat (12) cycle(0, 1, 0);
        chk("rand_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
